// File: rtl/row_mem_read_sched_if.sv
// Port-B read bus between the core start/done logic, the read sequencer and the PE array.
// The sequencer uses the slave modport.
interface row_mem_read_sched_if #(
    parameter int IA_ADDR_W = 6,
    parameter int W_ADDR_W  = 7
);
    logic                 start;
    logic [2:0]           K;
    logic [5:0]           IMG_W;
    logic [7:0]           OC;
    logic [2:0]           STRIDE;
    logic                 hold;
    logic                 rd_en;
    logic [IA_ADDR_W-1:0] ia_addr;
    logic [W_ADDR_W-1:0]  w_addr;
    logic                 pe_valid;
    logic                 pe_first;
    logic                 pe_last;
    logic [4:0]           pe_col;
    logic [4:0]           pe_oc;
    logic                 busy;
    logic                 done;
    logic                 cfg_err;

    modport master (
        output start, K, IMG_W, OC, STRIDE, hold,
        input  rd_en, ia_addr, w_addr, pe_valid, pe_first, pe_last,
               pe_col, pe_oc, busy, done, cfg_err
    );

    modport slave (
        input  start, K, IMG_W, OC, STRIDE, hold,
        output rd_en, ia_addr, w_addr, pe_valid, pe_first, pe_last,
               pe_col, pe_oc, busy, done, cfg_err
    );
endinterface

// File: rtl/row_mem_read_sched.sv
// Read-side sequencer for the IA and weight row memories: walks oc / x / kw, drives
// port-B enable and addresses, and delays PE tags by the row memory read latency.
//
// state | meaning
// IDLE  | waiting for start; config latched on an accepted start
// RUN   | issuing one read per cycle unless hold is high
// DRAIN | last read issued, waiting RD_LAT cycles for data to reach the PEs
// DONE  | one-cycle done pulse, back to IDLE
module row_mem_read_sched #(
    parameter int IA_ADDR_W = 6,
    parameter int W_ADDR_W  = 7,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    row_mem_read_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // {valid, first, last, col[4:0], oc[4:0]}
    localparam int TAG_W = 13;

    state_t                    state_q, state_d;
    logic [2:0]                k_q, k_d;
    logic [5:0]                imgw_q, imgw_d;
    logic [7:0]                oc_q, oc_d;
    logic [2:0]                stride_q, stride_d;
    logic                      cfg_err_q, cfg_err_d;
    logic [1:0]                kw_q, kw_d;
    logic [4:0]                x_q, x_d;
    logic [4:0]                occ_q, occ_d;
    logic [2:0]                drain_q, drain_d;
    logic [IA_ADDR_W-1:0]      ia_hold_q, ia_hold_d;
    logic [W_ADDR_W-1:0]       w_hold_q, w_hold_d;
    logic [RD_LAT-1:0][TAG_W-1:0] pipe_q, pipe_d;

    logic                      issue;
    logic                      kw_last, x_last, oc_last;
    logic                      cfg_legal;
    logic [IA_ADDR_W-1:0]      ia_cur;
    logic [W_ADDR_W-1:0]       w_cur;
    logic [TAG_W-1:0]          stage_in;
    logic [TAG_W-1:0]          pipe_out;

    // IMG_W=32 with STRIDE=2 would need ia_addr 64, so it is rejected here.
    assign cfg_legal = (bus.K >= 3'd1) && (bus.K <= 3'd3) &&
                       (bus.IMG_W != 6'd0) && (bus.IMG_W <= 6'd32) &&
                       (bus.OC != 8'd0) && (bus.OC <= 8'd32) &&
                       (bus.STRIDE >= 3'd1) && (bus.STRIDE <= 3'd2) &&
                       !((bus.STRIDE == 3'd2) && (bus.IMG_W == 6'd32));

    assign issue   = (state_q == RUN) && !bus.hold;
    assign kw_last = ({1'b0, kw_q} == (k_q - 3'd1));
    assign x_last  = ({1'b0, x_q} == (imgw_q - 6'd1));
    assign oc_last = ({3'b000, occ_q} == (oc_q - 8'd1));

    assign ia_cur = IA_ADDR_W'(x_q) * IA_ADDR_W'(stride_q) + IA_ADDR_W'(kw_q);
    assign w_cur  = W_ADDR_W'(occ_q) * W_ADDR_W'(k_q) + W_ADDR_W'(kw_q);

    assign stage_in = issue ? {1'b1, (kw_q == 2'd0), kw_last, x_q, occ_q} : '0;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        imgw_d    = imgw_q;
        oc_d      = oc_q;
        stride_d  = stride_q;
        cfg_err_d = cfg_err_q;
        kw_d      = kw_q;
        x_d       = x_q;
        occ_d     = occ_q;
        drain_d   = drain_q;
        ia_hold_d = ia_hold_q;
        w_hold_d  = w_hold_q;

        pipe_d    = pipe_q;
        pipe_d[0] = stage_in;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    k_d       = bus.K;
                    imgw_d    = bus.IMG_W;
                    oc_d      = bus.OC;
                    stride_d  = bus.STRIDE;
                    cfg_err_d = !cfg_legal;
                    kw_d      = 2'd0;
                    x_d       = 5'd0;
                    occ_d     = 5'd0;
                    state_d   = cfg_legal ? RUN : DONE;
                end
            end
            RUN: begin
                if (issue) begin
                    ia_hold_d = ia_cur;
                    w_hold_d  = w_cur;
                    if (kw_last && x_last && oc_last) begin
                        state_d = DRAIN;
                        drain_d = 3'(RD_LAT);
                    end else if (!kw_last) begin
                        kw_d = kw_q + 2'd1;
                    end else begin
                        kw_d = 2'd0;
                        if (!x_last) begin
                            x_d = x_q + 5'd1;
                        end else begin
                            x_d   = 5'd0;
                            occ_d = occ_q + 5'd1;
                        end
                    end
                end
            end
            DRAIN: begin
                if (drain_q <= 3'd1) begin
                    state_d = DONE;
                    drain_d = 3'd0;
                end else begin
                    drain_d = drain_q - 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            k_q       <= '0;
            imgw_q    <= '0;
            oc_q      <= '0;
            stride_q  <= '0;
            cfg_err_q <= 1'b0;
            kw_q      <= '0;
            x_q       <= '0;
            occ_q     <= '0;
            drain_q   <= '0;
            ia_hold_q <= '0;
            w_hold_q  <= '0;
            pipe_q    <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            imgw_q    <= imgw_d;
            oc_q      <= oc_d;
            stride_q  <= stride_d;
            cfg_err_q <= cfg_err_d;
            kw_q      <= kw_d;
            x_q       <= x_d;
            occ_q     <= occ_d;
            drain_q   <= drain_d;
            ia_hold_q <= ia_hold_d;
            w_hold_q  <= w_hold_d;
            pipe_q    <= pipe_d;
        end
    end

    assign pipe_out = pipe_q[RD_LAT-1];

    // Addresses follow the counters on an issue cycle and otherwise show the last issued read.
    assign bus.rd_en    = issue;
    assign bus.ia_addr  = issue ? ia_cur : ia_hold_q;
    assign bus.w_addr   = issue ? w_cur : w_hold_q;
    assign bus.pe_valid = pipe_out[12];
    assign bus.pe_first = pipe_out[11];
    assign bus.pe_last  = pipe_out[10];
    assign bus.pe_col   = pipe_out[9:5];
    assign bus.pe_oc    = pipe_out[4:0];
    assign bus.busy     = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done     = (state_q == DONE);
    assign bus.cfg_err  = cfg_err_q;

endmodule

// File: doc/row_mem_read_sched.md
Name: row_mem_read_sched

Overview:
- Read-side sequencer for the 96 IA row memories and 3 weight row memories inside the dense core.
- Runs after the row-memory load phase completes. Walks output channel, output column and kernel column in a fixed nested order, and drives the shared port-B enable and addresses.
- Emits latency-aligned valid/first/last/index tags so the PE array knows when to clear, accumulate and retire a partial sum.
- Sits between the core-level start/done logic and the PE array.

Parameters:
- IA_ADDR_W, 6, IA row memory port-B address width.
- W_ADDR_W, 7, weight row memory port-B address width.
- RD_LAT, 1, row memory read latency in cycles (1..4).

Ports:
- clk  in  1  core clock
- resetn  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; latches config and begins a pass (ignored unless IDLE)
- K  in  3  kernel size, legal 1..3
- IMG_W  in  6  output tile width, legal 1..32
- OC  in  8  output channels in tile, legal 1..32
- STRIDE  in  3  legal 1..2
- hold  in  1  PE back-pressure; freezes issue while high
- rd_en  out  1  broadcast enb to all IA and weight row memories
- ia_addr  out  IA_ADDR_W  broadcast IA addrb
- w_addr  out  W_ADDR_W  broadcast weight addrb
- pe_valid  out  1  row memory data valid at PE inputs this cycle
- pe_first  out  1  with pe_valid: first kernel tap, PE clears its accumulator
- pe_last  out  1  with pe_valid: last kernel tap, psum complete
- pe_col  out  5  output column tag aligned with pe_valid
- pe_oc  out  5  output channel tag aligned with pe_valid
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- cfg_err  out  1  set with done when the latched config is illegal

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE; all counters 0; every output 0; delay pipeline cleared.
  - Applies mid-pass too: pass aborted, no done pulse.
- State machine: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 latches K, IMG_W, OC and STRIDE; clears cfg_err.
  - Legal config: -> RUN.
  - Illegal config (K=0 or K>3, IMG_W=0, OC=0 or OC>32, STRIDE=0 or STRIDE>2): -> DONE with cfg_err=1. No rd_en is ever issued.
- RUN counters, innermost first:
  - kw 0..K-1, then x 0..IMG_W-1, then oc 0..OC-1.
  - Counters advance one step per issue cycle.
- Issue cycle (RUN and hold=0):
  - rd_en=1.
  - ia_addr = x*STRIDE + kw (max 31*2+2 = 64; legal configs keep it ≤ 63 only with STRIDE=2 and IMG_W≤31. IMG_W=32 with STRIDE=2 is therefore also flagged cfg_err).
  - w_addr = oc*K + kw (max 95).
- hold=1 in RUN:
  - rd_en=0; counters frozen; addresses hold their last value.
  - A bubble (valid=0) enters the delay pipeline.
- Last issue (oc=OC-1, x=IMG_W-1, kw=K-1):
  - Next state DRAIN with a drain counter = RUN_LAT = RD_LAT.
  - rd_en=0 from the next cycle.
- DRAIN: counts RD_LAT cycles regardless of hold, then -> DONE.
- DONE: done=1 for one cycle, busy=0, -> IDLE. cfg_err holds until the next accepted start.
- Delay pipeline:
  - Depth RD_LAT; carries {rd_en, kw==0, kw==K-1, x, oc}.
  - Output is pe_valid, pe_first, pe_last, pe_col, pe_oc.
  - pe_first, pe_last, pe_col and pe_oc are 0 whenever pe_valid=0.
- Totals and timing:
  - Total pe_valid cycles = OC*IMG_W*K.
  - With hold never asserted, done arrives RD_LAT+1 cycles after the last rd_en.
  - K=1: pe_first and pe_last are both set on every valid.
- Mid-pass behaviour:
  - start during RUN, DRAIN or DONE is ignored.
  - Config input changes mid-pass have no effect.
  - A start in the same cycle that done pulses is ignored; a new start is accepted only in IDLE.
- Arithmetic is unsigned with no wrap; the address bound is guaranteed by the legality check.

Test Plan:
- K=3, IMG_W=2, OC=1, STRIDE=1, RD_LAT=1 -> ia_addr 0,1,2,1,2,3; w_addr 0,1,2,0,1,2. pe_first on taps 1 and 4, pe_last on taps 3 and 6 (each one cycle after its rd_en). done 2 cycles after the last rd_en; 6 valids total.
- K=1, IMG_W=4, OC=2, STRIDE=2 -> ia_addr 0,2,4,6,0,2,4,6; w_addr 0,0,0,0,1,1,1,1. Every valid has first=last=1; pe_oc goes 0 then 1.
- hold high for 3 cycles mid-pass (K=3, IMG_W=3, OC=1) -> no rd_en and no address change during hold. The full 9-address sequence is intact, pe_valid shows a 3-cycle gap, and done is delayed by exactly 3 cycles.
- Illegal configs (K=0; separately OC=33; separately STRIDE=2 with IMG_W=32) -> done and cfg_err one cycle after start; rd_en never asserted.
- start pulsed again during RUN with a different K -> ignored; the original sequence completes unchanged and done pulses once.
- resetn=0 for 1 cycle mid-RUN -> next cycle all outputs 0 and state IDLE with no done. A subsequent start runs a full correct pass.
